// File: rtl/timer_capture.sv
// Timestamp capture FIFO: snapshots the live 64-bit count on each rising event edge.
// Optional threshold/overflow interrupt is compiled in with TIMER_CAPTURE_IRQ_EN.
module timer_capture #(
  parameter int DATA_W      = 32,
  parameter int FIFO_ADDR_W = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cke_i,
  input  logic [2*DATA_W-1:0]    time_i,
  input  logic                   event_i,
  input  logic                   pop_i,
  input  logic                   clr_ovf_i,
`ifdef TIMER_CAPTURE_IRQ_EN
  input  logic [FIFO_ADDR_W:0]   irq_thr_i,
  output logic                   irq_o,
`endif
  output logic [DATA_W-1:0]      data_low_o,
  output logic [DATA_W-1:0]      data_high_o,
  output logic [FIFO_ADDR_W:0]   level_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   overflow_o
);

  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W-1:0] PTR_ONE = {{(FIFO_ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [FIFO_ADDR_W:0]   LVL_ONE = {{FIFO_ADDR_W{1'b0}}, 1'b1};

  logic [2*DATA_W-1:0]    mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [FIFO_ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [FIFO_ADDR_W:0]   level_reg, level_next;
  logic                   ev_q_reg;
  logic [DATA_W-1:0]      shadow_reg, shadow_next;
  logic                   overflow_reg, overflow_next;

  logic [2*DATA_W-1:0] head;
  logic                empty, full, rise, do_pop, accept_push, drop;

  assign head   = mem[rd_ptr_reg];
  assign empty  = (level_reg == '0);
  // Level never exceeds DEPTH, so its MSB alone marks full.
  assign full   = level_reg[FIFO_ADDR_W];
  assign rise   = event_i & ~ev_q_reg;
  assign do_pop = pop_i & ~empty;
  assign accept_push = rise & (~full | do_pop);
  assign drop        = rise & full & ~do_pop;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    shadow_next   = shadow_reg;
    overflow_next = overflow_reg;
    if (accept_push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (do_pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
      shadow_next = head[2*DATA_W-1:DATA_W];
    end
    case ({accept_push, do_pop})
      2'b10:   level_next = level_reg + LVL_ONE;
      2'b01:   level_next = level_reg - LVL_ONE;
      default: level_next = level_reg;
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)           overflow_next = 1'b1;
    else if (clr_ovf_i) overflow_next = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      ev_q_reg     <= 1'b0;
      shadow_reg   <= '0;
      overflow_reg <= 1'b0;
    end else if (cke_i) begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      ev_q_reg     <= event_i;
      shadow_reg   <= shadow_next;
      overflow_reg <= overflow_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i && accept_push) mem[wr_ptr_reg] <= time_i;
  end

`ifdef TIMER_CAPTURE_IRQ_EN
  logic irq_reg;
  always_ff @(posedge clk_i) begin
    if (rst_i)      irq_reg <= 1'b0;
    else if (cke_i) irq_reg <= (irq_thr_i != '0) ? (level_reg >= irq_thr_i) : overflow_reg;
  end
  assign irq_o = irq_reg;
`endif

  assign data_low_o  = empty ? '0 : head[DATA_W-1:0];
  assign data_high_o = shadow_reg;
  assign level_o     = level_reg;
  assign empty_o     = empty;
  assign full_o      = full;
  assign overflow_o  = overflow_reg;

endmodule
